// File: rtl/modular_exponentiation.sv
// Modular exponentiation, result = base^exponent mod modulus.
// Right-to-left binary square-and-multiply around one external
// multiplication_modulo unit that is reused serially.
//
// state        | meaning
// -------------+------------------------------------------------------
// S_IDLE       | collecting base / exponent / modulus, any order
// S_CHECK      | one cycle of trivial-case detection, sets r = 1
// S_MUL_ISSUE  | offering (r, b, m) to the multiplier
// S_MUL_WAIT   | waiting for r*b mod m
// S_SQR_ISSUE  | offering (b, b, m) to the multiplier
// S_SQR_WAIT   | waiting for b*b mod m
// S_DONE       | result held on the output until it is accepted
module modular_exponentiation #(
    parameter int SIZE = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] input_base_tdata,
    input  logic            input_base_tvalid,
    output logic            input_base_tready,
    input  logic [SIZE-1:0] input_exponent_tdata,
    input  logic            input_exponent_tvalid,
    output logic            input_exponent_tready,
    input  logic [SIZE-1:0] input_modulus_tdata,
    input  logic            input_modulus_tvalid,
    output logic            input_modulus_tready,
    output logic [SIZE-1:0] mul_multiplier_tdata,
    output logic            mul_multiplier_tvalid,
    input  logic            mul_multiplier_tready,
    output logic [SIZE-1:0] mul_multiplicand_tdata,
    output logic            mul_multiplicand_tvalid,
    input  logic            mul_multiplicand_tready,
    output logic [SIZE-1:0] mul_modulus_tdata,
    output logic            mul_modulus_tvalid,
    input  logic            mul_modulus_tready,
    input  logic [SIZE-1:0] mul_result_tdata,
    input  logic            mul_result_tvalid,
    output logic            mul_result_tready,
    output logic [SIZE-1:0] output_tdata,
    output logic            output_tvalid,
    input  logic            output_tready,
    output logic            output_error,
    output logic            busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_SQR_ISSUE,
        S_SQR_WAIT,
        S_DONE
    } state_t;

    state_t          r_state;
    logic            r_cap_base, r_cap_exp, r_cap_mod;
    logic [SIZE-1:0] r_r, r_b, r_e, r_m;
    // Set when the exponent was already shifted by the multiply step of
    // the current bit, so the following square must not shift it again.
    logic            r_e_shifted;
    logic            r_mul_a_valid, r_mul_b_valid, r_mul_m_valid;
    logic [SIZE-1:0] r_mul_a_data, r_mul_b_data, r_mul_m_data;
    logic            r_res_ready;
    logic            r_out_valid, r_out_error, r_busy;
    logic [SIZE-1:0] r_out_data;

    logic            w_base_hs, w_exp_hs, w_mod_hs, w_all_captured;
    logic            w_issue_done, w_res_hs;
    logic [SIZE-1:0] w_e_half, w_e_sqr_next;

    assign input_base_tready     = (r_state == S_IDLE) && !r_cap_base;
    assign input_exponent_tready = (r_state == S_IDLE) && !r_cap_exp;
    assign input_modulus_tready  = (r_state == S_IDLE) && !r_cap_mod;

    assign w_base_hs      = input_base_tvalid && input_base_tready;
    assign w_exp_hs       = input_exponent_tvalid && input_exponent_tready;
    assign w_mod_hs       = input_modulus_tvalid && input_modulus_tready;
    assign w_all_captured = (r_cap_base || w_base_hs) && (r_cap_exp || w_exp_hs)
                            && (r_cap_mod || w_mod_hs);

    // Issue completes when no channel still has an un-accepted offer.
    assign w_issue_done = !((r_mul_a_valid && !mul_multiplier_tready)
                         || (r_mul_b_valid && !mul_multiplicand_tready)
                         || (r_mul_m_valid && !mul_modulus_tready));
    assign w_res_hs     = r_res_ready && mul_result_tvalid;
    assign w_e_half     = r_e >> 1;
    assign w_e_sqr_next = r_e_shifted ? r_e : w_e_half;

    assign mul_multiplier_tdata    = r_mul_a_data;
    assign mul_multiplier_tvalid   = r_mul_a_valid;
    assign mul_multiplicand_tdata  = r_mul_b_data;
    assign mul_multiplicand_tvalid = r_mul_b_valid;
    assign mul_modulus_tdata       = r_mul_m_data;
    assign mul_modulus_tvalid      = r_mul_m_valid;
    assign mul_result_tready       = r_res_ready;
    assign output_tdata            = r_out_data;
    assign output_tvalid           = r_out_valid;
    assign output_error            = r_out_error;
    assign busy                    = r_busy;

    // Sequencer: operand capture, square-and-multiply iteration, result hold.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_cap_base    <= 1'b0;
            r_cap_exp     <= 1'b0;
            r_cap_mod     <= 1'b0;
            r_r           <= '0;
            r_b           <= '0;
            r_e           <= '0;
            r_m           <= '0;
            r_e_shifted   <= 1'b0;
            r_mul_a_valid <= 1'b0;
            r_mul_b_valid <= 1'b0;
            r_mul_m_valid <= 1'b0;
            r_mul_a_data  <= '0;
            r_mul_b_data  <= '0;
            r_mul_m_data  <= '0;
            r_res_ready   <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_error   <= 1'b0;
            r_out_data    <= '0;
            r_busy        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_base_hs) begin
                        r_b        <= input_base_tdata;
                        r_cap_base <= 1'b1;
                    end
                    if (w_exp_hs) begin
                        r_e       <= input_exponent_tdata;
                        r_cap_exp <= 1'b1;
                    end
                    if (w_mod_hs) begin
                        r_m       <= input_modulus_tdata;
                        r_cap_mod <= 1'b1;
                    end
                    if (w_all_captured) begin
                        r_cap_base <= 1'b0;
                        r_cap_exp  <= 1'b0;
                        r_cap_mod  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_r         <= SIZE'(1);
                    r_e_shifted <= 1'b0;
                    if (r_m == '0) begin
                        r_out_data  <= '0;
                        r_out_error <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_m == SIZE'(1)) begin
                        r_out_data  <= '0;
                        r_out_error <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_e == '0) begin
                        r_out_data  <= SIZE'(1);
                        r_out_error <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        // First multiply uses r = 1 directly; r_r lands this same edge.
                        r_mul_a_data  <= r_e[0] ? SIZE'(1) : r_b;
                        r_mul_b_data  <= r_b;
                        r_mul_m_data  <= r_m;
                        r_mul_a_valid <= 1'b1;
                        r_mul_b_valid <= 1'b1;
                        r_mul_m_valid <= 1'b1;
                        r_state       <= r_e[0] ? S_MUL_ISSUE : S_SQR_ISSUE;
                    end
                end
                S_MUL_ISSUE, S_SQR_ISSUE: begin
                    r_mul_a_valid <= r_mul_a_valid && !mul_multiplier_tready;
                    r_mul_b_valid <= r_mul_b_valid && !mul_multiplicand_tready;
                    r_mul_m_valid <= r_mul_m_valid && !mul_modulus_tready;
                    if (w_issue_done) begin
                        r_res_ready <= 1'b1;
                        r_state     <= (r_state == S_MUL_ISSUE) ? S_MUL_WAIT : S_SQR_WAIT;
                    end
                end
                S_MUL_WAIT: begin
                    if (w_res_hs) begin
                        r_res_ready <= 1'b0;
                        r_r         <= mul_result_tdata;
                        r_e         <= w_e_half;
                        r_e_shifted <= 1'b1;
                        if (w_e_half == '0) begin
                            // Top bit consumed: the trailing square would be wasted.
                            r_out_data  <= mul_result_tdata;
                            r_out_error <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_mul_a_data  <= r_b;
                            r_mul_b_data  <= r_b;
                            r_mul_m_data  <= r_m;
                            r_mul_a_valid <= 1'b1;
                            r_mul_b_valid <= 1'b1;
                            r_mul_m_valid <= 1'b1;
                            r_state       <= S_SQR_ISSUE;
                        end
                    end
                end
                S_SQR_WAIT: begin
                    if (w_res_hs) begin
                        r_res_ready <= 1'b0;
                        r_b         <= mul_result_tdata;
                        r_e         <= w_e_sqr_next;
                        r_e_shifted <= 1'b0;
                        if (w_e_sqr_next == '0) begin
                            r_out_data  <= r_r;
                            r_out_error <= 1'b0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_mul_a_data  <= w_e_sqr_next[0] ? r_r : mul_result_tdata;
                            r_mul_b_data  <= mul_result_tdata;
                            r_mul_m_data  <= r_m;
                            r_mul_a_valid <= 1'b1;
                            r_mul_b_valid <= 1'b1;
                            r_mul_m_valid <= 1'b1;
                            r_state       <= w_e_sqr_next[0] ? S_MUL_ISSUE : S_SQR_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (output_tready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
